// File: rtl/counter_run_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : counter_run_controller_pkg
// Brief  : Shared state encoding and default sizing for the run controller.
// Rev    : 1.0
// ============================================================================
package counter_run_controller_pkg;

    localparam int DEF_TICK_DIV = 50000000;
    localparam int DEF_CNT_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_LOAD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Prescaler register width; TICK_DIV is at least 2, so this is never 0.
    function automatic int prescale_bits(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_run_controller_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module : tick_prescaler
// Brief  : Free-running 0..TICK_DIV-1 counter with a strobe on the last count;
//          held at zero whenever run is low.
// Rev    : 1.0
// ============================================================================
module tick_prescaler
    import counter_run_controller_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int             c_W    = prescale_bits(TICK_DIV);
    localparam logic [c_W-1:0] c_LAST = c_W'(TICK_DIV - 1);
    localparam logic [c_W-1:0] c_ONE  = c_W'(1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || !run) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_ONE;
        end
    end

    assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/counter_run_controller.sv
`default_nettype none
// ============================================================================
// Module : counter_run_controller
// Brief  : Turns board start/step/clear commands into one-cycle enable and
//          load strobes for an external up/down counter.
// Rev    : 1.0
// ============================================================================
module counter_run_controller
    import counter_run_controller_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_stop_i,
    input  logic             step_i,
    input  logic             clear_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_ld,
    output logic [CNT_W-1:0] cnt_ld_val,
    output logic             tick,
    output logic             running,
    output logic             done
);

    state_t     r_state;
    logic       r_restart;
    logic       r_cnt_en;
    logic       r_cnt_ld;
    logic       r_cnt_up;
    logic       r_ss_d;
    logic       r_step_d;
    logic       r_clr_d;

    logic             w_ss_edge;
    logic             w_step_edge;
    logic             w_clr_edge;
    logic [CNT_W-1:0] w_term;
    logic             w_stop_oneshot;
    logic             w_tick;
    logic             w_run_hold;

    // Delay registers come out of reset high so a level held through reset is not an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ss_d   <= 1'b1;
            r_step_d <= 1'b1;
            r_clr_d  <= 1'b1;
        end else begin
            r_ss_d   <= start_stop_i;
            r_step_d <= step_i;
            r_clr_d  <= clear_i;
        end
    end

    assign w_ss_edge      = start_stop_i & ~r_ss_d;
    assign w_step_edge    = step_i & ~r_step_d;
    assign w_clr_edge     = clear_i & ~r_clr_d;

    assign w_term         = r_cnt_up ? '1 : '0;
    assign w_stop_oneshot = mode_i && (cnt_q == w_term);

    // Prescaler only advances while RUN is being kept, so it is zero on every RUN entry.
    assign w_run_hold = (r_state == ST_RUN) && !w_clr_edge && !w_ss_edge
                        && !(w_tick && w_stop_oneshot);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .run   (w_run_hold),
        .tick  (w_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_restart <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_cnt_ld  <= 1'b0;
            r_cnt_up  <= 1'b1;
        end else begin
            r_cnt_en <= 1'b0;
            r_cnt_ld <= 1'b0;
            if (r_state == ST_IDLE || r_state == ST_DONE) begin
                r_cnt_up <= dir_i;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_clr_edge) begin
                        r_state   <= ST_LOAD;
                        r_restart <= 1'b0;
                    end else if (w_ss_edge) begin
                        r_state <= ST_RUN;
                    end else if (w_step_edge) begin
                        r_state <= ST_STEP;
                    end
                end

                ST_RUN: begin
                    if (w_clr_edge) begin
                        r_state   <= ST_LOAD;
                        r_restart <= 1'b0;
                    end else if (w_ss_edge) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        if (w_stop_oneshot) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt_en <= 1'b1;
                        end
                    end
                end

                ST_STEP: begin
                    if (w_stop_oneshot) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt_en <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end

                ST_LOAD: begin
                    r_cnt_ld <= 1'b1;
                    r_state  <= r_restart ? ST_RUN : ST_IDLE;
                end

                ST_DONE: begin
                    if (w_clr_edge) begin
                        r_state   <= ST_LOAD;
                        r_restart <= 1'b0;
                    end else if (w_ss_edge) begin
                        r_state   <= ST_LOAD;
                        r_restart <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cnt_en     = r_cnt_en;
    assign cnt_ld     = r_cnt_ld;
    assign cnt_up     = r_cnt_up;
    assign cnt_ld_val = r_cnt_up ? '0 : '1;
    assign tick       = w_tick;
    assign running    = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_counter_run_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_counter_run_controller
// Brief  : Scoreboard bench: an event-time reference model predicts status and
//          strobes; a negedge monitor compares against the controller.
// Rev    : 1.0
// ============================================================================
module tb_counter_run_controller;

    localparam int             TICK_DIV = 4;
    localparam int             CNT_W    = 4;
    localparam logic [CNT_W-1:0] c_ONES = '1;
    localparam logic [CNT_W-1:0] c_ZERO = '0;

    logic             clock        = 1'b0;
    logic             reset        = 1'b1;
    logic             start_stop_i = 1'b1;
    logic             step_i       = 1'b0;
    logic             clear_i      = 1'b0;
    logic             dir_i        = 1'b1;
    logic             mode_i       = 1'b0;
    logic [CNT_W-1:0] cnt_q        = '0;
    logic             cnt_en;
    logic             cnt_up;
    logic             cnt_ld;
    logic [CNT_W-1:0] cnt_ld_val;
    logic             tick;
    logic             running;
    logic             done;

    counter_run_controller #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start_stop_i (start_stop_i),
        .step_i       (step_i),
        .clear_i      (clear_i),
        .dir_i        (dir_i),
        .mode_i       (mode_i),
        .cnt_q        (cnt_q),
        .cnt_en       (cnt_en),
        .cnt_up       (cnt_up),
        .cnt_ld       (cnt_ld),
        .cnt_ld_val   (cnt_ld_val),
        .tick         (tick),
        .running      (running),
        .done         (done)
    );

    always #5 clock = ~clock;

    // Behavioural counter datapath driven by the controller.
    always @(posedge clock) begin
        if (reset)       cnt_q <= '0;
        else if (cnt_ld) cnt_q <= cnt_ld_val;
        else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end

    typedef struct {
        int  cyc;
        bit  s_run;
        bit  s_done;
        bit  s_up;
        bit  s_tick;
    } status_t;

    typedef struct {
        int               cyc;
        bit               is_load;
        logic [CNT_W-1:0] val;
    } pulse_t;

    status_t status_q[$];
    pulse_t  pulse_q[$];
    int      cyc      = 0;
    int      checks   = 0;
    int      failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: tracks activity as flags plus the absolute cycle of the next tick.
    bit m_run = 0, m_done = 0, m_step = 0, m_load = 0, m_restart = 0, m_up = 1;
    bit p_ss = 1, p_st = 1, p_cl = 1;
    int tick_at = 0;

    always @(posedge clock) begin
        bit e_ss, e_st, e_cl, at_term, follow_dir;
        int nxt;
        #3;
        nxt = cyc + 1;
        if (reset) begin
            m_run = 0; m_done = 0; m_step = 0; m_load = 0; m_restart = 0; m_up = 1;
            p_ss = 1; p_st = 1; p_cl = 1;
        end else begin
            e_ss = start_stop_i && !p_ss;
            e_st = step_i && !p_st;
            e_cl = clear_i && !p_cl;
            p_ss = start_stop_i; p_st = step_i; p_cl = clear_i;
            at_term    = (cnt_q == (m_up ? c_ONES : c_ZERO));
            follow_dir = !(m_run || m_step || m_load);
            if (m_load) begin
                m_load = 0;
                pulse_q.push_back('{nxt, 1'b1, (m_up ? c_ZERO : c_ONES)});
                if (m_restart) begin
                    m_run   = 1;
                    tick_at = nxt + TICK_DIV - 1;
                end
            end else if (m_step) begin
                m_step = 0;
                if (mode_i && at_term) m_done = 1;
                else pulse_q.push_back('{nxt, 1'b0, c_ZERO});
            end else if (m_run) begin
                if (e_cl) begin
                    m_run = 0; m_load = 1; m_restart = 0;
                end else if (e_ss) begin
                    m_run = 0;
                end else if (cyc == tick_at) begin
                    if (mode_i && at_term) begin
                        m_run = 0; m_done = 1;
                    end else begin
                        pulse_q.push_back('{nxt, 1'b0, c_ZERO});
                        tick_at = tick_at + TICK_DIV;
                    end
                end
            end else if (m_done) begin
                if (e_cl) begin
                    m_done = 0; m_load = 1; m_restart = 0;
                end else if (e_ss) begin
                    m_done = 0; m_load = 1; m_restart = 1;
                end
            end else begin
                if (e_cl) begin
                    m_load = 1; m_restart = 0;
                end else if (e_ss) begin
                    m_run   = 1;
                    tick_at = nxt + TICK_DIV - 1;
                end else if (e_st) begin
                    m_step = 1;
                end
            end
            if (follow_dir) m_up = dir_i;
        end
        status_q.push_back('{nxt, m_run, m_done, m_up, (m_run && tick_at == nxt)});
    end

    // Monitor: compares strobes and per-cycle status against the scoreboard queues.
    always @(negedge clock) begin
        pulse_t  p;
        status_t s;
        while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
            p = pulse_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_pulse cyc=%0d: saw none, required %s", p.cyc, p.is_load ? "cnt_ld" : "cnt_en");
        end
        if (cnt_en || cnt_ld) begin
            checks++;
            if (cnt_en && cnt_ld) begin
                failures++;
                $display("FAIL en_ld_overlap cyc=%0d: both strobes high, required at most one", cyc);
            end else if (pulse_q.size() == 0 || pulse_q[0].cyc != cyc) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d: en=%0b ld=%0b, required no strobe", cyc, cnt_en, cnt_ld);
            end else begin
                p = pulse_q.pop_front();
                if (p.is_load != cnt_ld || (p.is_load && p.val !== cnt_ld_val)) begin
                    failures++;
                    $display("FAIL pulse_kind cyc=%0d: en=%0b ld=%0b val=%0h, required ld=%0b val=%0h",
                             cyc, cnt_en, cnt_ld, cnt_ld_val, p.is_load, p.val);
                end
            end
        end
        if (status_q.size() > 0 && status_q[0].cyc == cyc) begin
            s = status_q.pop_front();
            checks++;
            if ({running, done, cnt_up, tick} !== {s.s_run, s.s_done, s.s_up, s.s_tick} ||
                cnt_ld_val !== (s.s_up ? c_ZERO : c_ONES)) begin
                failures++;
                $display("FAIL status cyc=%0d: run=%0b done=%0b up=%0b tick=%0b ldv=%0h, required run=%0b done=%0b up=%0b tick=%0b",
                         cyc, running, done, cnt_up, tick, cnt_ld_val, s.s_run, s.s_done, s.s_up, s.s_tick);
            end
        end
    end

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_val(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_q(input string name, input logic [CNT_W-1:0] v, input int limit);
        int n;
        n = 0;
        while (cnt_q !== v && n < limit) begin
            step_cycles(1);
            n++;
        end
        check_val(name, cnt_q, v);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            step_cycles(1);
            n++;
        end
        check_val("reach_done", {3'b0, done}, 4'd1);
    endtask

    initial begin
        int n;
        // Reset with start_stop held high: no edge after release.
        step_cycles(4);
        reset = 1'b0;
        step_cycles(20);
        check_val("idle_hold_q", cnt_q, 4'h0);
        check_val("idle_hold_run", {3'b0, running}, 4'd0);

        // Free-run up with wrap.
        start_stop_i = 1'b0; step_cycles(1);
        start_stop_i = 1'b1; step_cycles(1);
        wait_q("reach_F", 4'hF, 100);
        wait_q("wrap_0", 4'h0, 10);
        check_val("wrap_running", {3'b0, running}, 4'd1);

        // Pause, one-shot down from F after clear.
        start_stop_i = 1'b0; step_cycles(1);
        start_stop_i = 1'b1; step_cycles(3);
        mode_i = 1'b1; dir_i = 1'b0; step_cycles(2);
        clear_i = 1'b1; step_cycles(1);
        clear_i = 1'b0; step_cycles(3);
        check_val("clear_load_F", cnt_q, 4'hF);
        start_stop_i = 1'b0; step_cycles(1);
        start_stop_i = 1'b1; step_cycles(1);
        wait_done(100);
        check_val("done_q0", cnt_q, 4'h0);
        check_val("done_not_running", {3'b0, running}, 4'd0);

        // Restart from DONE counting up.
        dir_i = 1'b1; step_cycles(2);
        start_stop_i = 1'b0; step_cycles(1);
        start_stop_i = 1'b1; step_cycles(1);
        wait_q("restart_count", 4'h1, 20);
        start_stop_i = 1'b0; step_cycles(1);
        start_stop_i = 1'b1; step_cycles(2);

        // Single-step to 5, then one more.
        n = 0;
        while (cnt_q !== 4'h5 && n < 10) begin
            step_i = 1'b1; step_cycles(1);
            step_i = 1'b0; step_cycles(3);
            n++;
        end
        check_val("step_to_5", cnt_q, 4'h5);
        step_i = 1'b1; step_cycles(1);
        step_i = 1'b0; step_cycles(3);
        check_val("step_to_6", cnt_q, 4'h6);
        check_val("step_idle", {3'b0, running}, 4'd0);

        // Step and start together: start wins.
        start_stop_i = 1'b0; step_cycles(1);
        step_i = 1'b1; start_stop_i = 1'b1; step_cycles(1);
        step_i = 1'b0; step_cycles(2);
        check_val("start_wins_run", {3'b0, running}, 4'd1);
        check_val("start_wins_q", cnt_q, 4'h6);

        // Reset while the prescaler sits at 2.
        n = 0;
        while (tick !== 1'b1 && n < 10) begin
            step_cycles(1);
            n++;
        end
        step_cycles(3);
        reset = 1'b1; step_cycles(1);
        reset = 1'b0;
        check_val("rst_outs", {cnt_en, cnt_ld, running, done}, 4'b0000);
        check_val("rst_up", {3'b0, cnt_up}, 4'd1);

        // Clear and start together in RUN: load then idle.
        start_stop_i = 1'b0; step_cycles(1);
        start_stop_i = 1'b1; step_cycles(2);
        start_stop_i = 1'b0; step_cycles(1);
        clear_i = 1'b1; start_stop_i = 1'b1; step_cycles(1);
        clear_i = 1'b0; step_cycles(3);
        check_val("clr_ss_idle", {2'b0, running, done}, 4'd0);
        check_val("clr_ss_q", cnt_q, 4'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0)   start_stop_i = ~start_stop_i;
            if ($urandom_range(7) == 0)   step_i = ~step_i;
            if ($urandom_range(19) == 0)  clear_i = ~clear_i;
            if ($urandom_range(9) == 0)   dir_i = ~dir_i;
            if ($urandom_range(15) == 0)  mode_i = ~mode_i;
            reset = ($urandom_range(299) == 0);
            step_cycles(1);
        end
        reset = 1'b0;
        step_cycles(10);
        checks++;
        if (pulse_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d strobes outstanding, required 0", pulse_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
